reg_file_ctrl: RTL

Parametrised register file for the Janus datapath: NUM_REGS general-purpose registers plus a program counter (PC) at index NUM_REGS.
- Writes: a four-phase req/ack handshake, with a selectable input source and a half-word write mode.
- Reads: NUM_RD registered read ports with write-through bypass.
- Also provides a per-register clear and PC auto-increment.
- Sits between instruction decode/control and the ALU/memory interface.

---
 rtl/reg_file_pkg.sv | 34 +++
 rtl/reg_wr_hs_fsm.sv | 53 +++++
 rtl/reg_file_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared encodings and helpers for the Janus register file controller.
package reg_file_pkg;

    // Write source select encodings (ip_sel); codes 5-7 select zero.
    localparam logic [2:0] SRC_ALU  = 3'd0;
    localparam logic [2:0] SRC_DIB  = 3'd1;
    localparam logic [2:0] SRC_IMMZ = 3'd2;
    localparam logic [2:0] SRC_IMMS = 3'd3;
    localparam logic [2:0] SRC_RTR  = 3'd4;

    // Write mode encodings (hl_sel); 2'b11 behaves as a full-word write.
    localparam logic [1:0] HL_FULL = 2'b00;
    localparam logic [1:0] HL_LOW  = 2'b01;
    localparam logic [1:0] HL_HIGH = 2'b10;

    // Write handshake states.
    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        ACK,
        HOLD
    } wr_state_e;

    // Ceiling log2, used to size register indices.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_wr_hs_fsm.sv
// Four-phase write handshake sequencer: capture, commit, acknowledge, wait for release.
module reg_wr_hs_fsm
    import reg_file_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wr_req,
    output logic cap_en,
    output logic commit_en,
    output logic wr_ack
);

    wr_state_e state;

    // Capture happens on the same edge the request is first seen, so it cannot be registered.
    assign cap_en = (state == IDLE) && wr_req;

    // State register with registered commit and acknowledge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            commit_en <= 1'b0;
            wr_ack    <= 1'b0;
        end else begin
            commit_en <= 1'b0;
            wr_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state     <= COMMIT;
                        commit_en <= 1'b1;
                    end
                end
                COMMIT: begin
                    state  <= ACK;
                    wr_ack <= 1'b1;
                end
                ACK: begin
                    state <= wr_req ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!wr_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Janus register file: NUM_REGS general registers plus PC at index NUM_REGS, handshaked
// writes with source/half-word selection, per-register clear, PC increment and
// registered read ports with write-through bypass.
module reg_file_ctrl
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 4,
    parameter int IMM_W    = 16,
    parameter int PC_STEP  = 4,
    localparam int SEL_W   = clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic [DATA_W-1:0]        dib,
    input  logic [IMM_W-1:0]         id_imme,
    input  logic [2:0]               ip_sel,
    input  logic [1:0]               hl_sel,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic                     wr_req,
    output logic                     wr_ack,
    output logic                     wr_err,
    input  logic [SEL_W-1:0]         rtr_sel,
    input  logic                     clr,
    input  logic [SEL_W-1:0]         clr_sel,
    input  logic                     pc_incr,
    input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]        pc_out
);

    localparam int HALF_W  = DATA_W / 2;
    localparam int NUM_ENT = NUM_REGS + 1;
    localparam logic [SEL_W-1:0] PC_IDX = SEL_W'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_ENT];
    logic [DATA_W-1:0] regs_d [NUM_ENT];

    logic              cap_en;
    logic              commit_en;
    logic [DATA_W-1:0] cap_src_q;
    logic [1:0]        cap_hl_q;
    logic [SEL_W-1:0]  cap_sel_q;

    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rtr_val;
    logic [DATA_W-1:0] src_word;
    logic [DATA_W-1:0] commit_old;
    logic [DATA_W-1:0] commit_word;
    logic [DATA_W-1:0] rd_next [NUM_RD];

    reg_wr_hs_fsm u_hs_fsm (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .cap_en    (cap_en),
        .commit_en (commit_en),
        .wr_ack    (wr_ack)
    );

    // Immediate extension; loop form keeps IMM_W == DATA_W legal.
    always_comb begin
        imm_zext = '0;
        imm_zext[IMM_W-1:0] = id_imme;
        imm_sext = imm_zext;
        for (int i = IMM_W; i < DATA_W; i++) begin
            imm_sext[i] = id_imme[IMM_W-1];
        end
    end

    // Write source selection, evaluated against pre-edge register contents.
    always_comb begin
        rtr_val = (rtr_sel <= PC_IDX) ? regs_q[rtr_sel] : '0;
        case (ip_sel)
            SRC_ALU:  src_word = alu_out;
            SRC_DIB:  src_word = dib;
            SRC_IMMZ: src_word = imm_zext;
            SRC_IMMS: src_word = imm_sext;
            SRC_RTR:  src_word = rtr_val;
            default:  src_word = '0;
        endcase
    end

    // Capture registers for the pending write transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_src_q <= '0;
            cap_hl_q  <= HL_FULL;
            cap_sel_q <= '0;
        end else if (cap_en) begin
            cap_src_q <= src_word;
            cap_hl_q  <= hl_sel;
            cap_sel_q <= wr_sel;
        end
    end

    // Half-word merge against the target's value at the commit edge.
    always_comb begin
        commit_old = (cap_sel_q <= PC_IDX) ? regs_q[cap_sel_q] : '0;
        case (cap_hl_q)
            HL_LOW:  commit_word = {commit_old[DATA_W-1:HALF_W], cap_src_q[HALF_W-1:0]};
            HL_HIGH: commit_word = {cap_src_q[HALF_W-1:0], commit_old[HALF_W-1:0]};
            default: commit_word = cap_src_q;
        endcase
    end

    // Next-state of every entry: clear beats commit, and both beat the PC increment.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            regs_d[i] = regs_q[i];
            if (clr && (clr_sel == SEL_W'(i))) begin
                regs_d[i] = '0;
            end else if (commit_en && (cap_sel_q == SEL_W'(i))) begin
                regs_d[i] = commit_word;
            end else if ((i == NUM_REGS) && pc_incr) begin
                regs_d[i] = regs_q[i] + DATA_W'(PC_STEP);
            end
        end
    end

    // Storage array update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports look at next-state values so same-edge updates are visible.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_next[k] = (rd_sel[k*SEL_W +: SEL_W] <= PC_IDX) ?
                         regs_d[rd_sel[k*SEL_W +: SEL_W]] : '0;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data[k*DATA_W +: DATA_W] <= rd_next[k];
            end
        end
    end

    // Error flag rises on the commit edge so it lines up with wr_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= commit_en && (cap_sel_q > PC_IDX);
        end
    end

    assign pc_out = regs_q[NUM_REGS];

endmodule
